// File: rtl/wb_mux_arb.sv
// Write-back select stage: picks one of NUM_SRC sources by forced select or by
// arbitration, and registers it into a single valid/ready output slot.
module wb_mux_arb #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int RR      = 1,
    localparam int SELW   = $clog2(NUM_SRC)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [NUM_SRC*WIDTH-1:0] data,
    input  logic                     force_en,
    input  logic [SELW-1:0]          force_sel,
    output logic [NUM_SRC-1:0]       gnt,
    output logic [WIDTH-1:0]         wData,
    output logic [SELW-1:0]          src_id,
    output logic                     wValid,
    input  logic                     wReady
);

    // Slots beyond NUM_SRC read as zero so a select index never leaves the array.
    localparam int NSLOT = 1 << SELW;

    logic [WIDTH-1:0] src_data [NSLOT];
    logic [NSLOT-1:0] req_pad;

    logic [WIDTH-1:0] wdata_reg;
    logic [SELW-1:0]  src_id_reg;
    logic             wvalid_reg;
    logic [SELW-1:0]  ptr_reg;
    logic [SELW-1:0]  ptr_next;

    logic [SELW-1:0]  win;
    logic [SELW-1:0]  sel;
    logic             found;
    logic             accept;
    logic             load;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NUM_SRC) begin : g_src
                assign src_data[gi] = data[gi*WIDTH +: WIDTH];
                assign req_pad[gi]  = req[gi];
            end else begin : g_pad
                assign src_data[gi] = '0;
                assign req_pad[gi]  = 1'b0;
            end
        end
    endgenerate

    // Search order starts at the pointer in round-robin mode, at 0 otherwise.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int              j;
            logic [SELW-1:0] idx;
            j = (RR != 0) ? int'(ptr_reg) + k : k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            idx = SELW'(j);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        accept   = !wvalid_reg || wReady;
        sel      = force_en ? force_sel : win;
        load     = accept && (force_en || found);
        ptr_next = (win == SELW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        gnt      = '0;
        if (!Reset && load) begin
            gnt = NUM_SRC'(1) << sel;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wdata_reg  <= '0;
            src_id_reg <= '0;
            wvalid_reg <= 1'b0;
            ptr_reg    <= '0;
        end else if (accept) begin
            if (load) begin
                wdata_reg  <= src_data[sel];
                src_id_reg <= sel;
                wvalid_reg <= 1'b1;
                // Forced selects leave the fairness pointer untouched.
                if (!force_en) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                wvalid_reg <= 1'b0;
            end
        end
    end

    assign wData  = wdata_reg;
    assign src_id = src_id_reg;
    assign wValid = wvalid_reg;

endmodule

// File: tb/tb_wb_mux_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus,
// a queue-based reference model predicts grants and output registers per cycle.
module tb_wb_mux_arb;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data = '0;
    logic           force_en = 1'b0;
    logic [SW-1:0]  force_sel = '0;
    logic           wReady = 1'b0;

    logic [N-1:0]   gnt_o   [2];
    logic [W-1:0]   wdata_o [2];
    logic [SW-1:0]  id_o    [2];
    logic           valid_o [2];

    always #5 Clk = ~Clk;

    wb_mux_arb #(.WIDTH(W), .NUM_SRC(N), .RR(1)) u_rr (
        .Clk(Clk), .Reset(Reset), .req(req), .data(data),
        .force_en(force_en), .force_sel(force_sel), .gnt(gnt_o[0]),
        .wData(wdata_o[0]), .src_id(id_o[0]), .wValid(valid_o[0]), .wReady(wReady)
    );

    wb_mux_arb #(.WIDTH(W), .NUM_SRC(N), .RR(0)) u_fp (
        .Clk(Clk), .Reset(Reset), .req(req), .data(data),
        .force_en(force_en), .force_sel(force_sel), .gnt(gnt_o[1]),
        .wData(wdata_o[1]), .src_id(id_o[1]), .wValid(valid_o[1]), .wReady(wReady)
    );

    typedef struct {
        logic [1:0][N-1:0]  gnt;
        logic [1:0]         valid;
        logic [1:0][W-1:0]  dat;
        logic [1:0][SW-1:0] id;
    } exp_t;

    exp_t sb[$];

    // Reference model state; index 0 = round-robin, 1 = fixed priority.
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_id    [2];
    int           m_ptr   [2];
    int           pend_w  [2];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, m, act, exp, $time);
    endtask

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_id[m]    = 0;
            m_ptr[m]   = 0;
            pend_w[m]  = -1;
        end
    endfunction

    // Winner index for this cycle, or -1 when nothing is granted.
    function automatic int pick(input int m);
        int idx;
        if (Reset) return -1;
        if (m_valid[m] && !wReady) return -1;
        if (force_en) return int'(force_sel);
        for (int k = 0; k < N; k++) begin
            idx = (m == 0) ? (m_ptr[m] + k) % N : k;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            pend_w[m]  = pick(m);
            e.gnt[m]   = (pend_w[m] >= 0) ? (N'(1) << pend_w[m]) : '0;
            e.valid[m] = m_valid[m];
            e.dat[m]   = m_data[m];
            e.id[m]    = SW'(m_id[m]);
        end
        sb.push_back(e);
    endtask

    task automatic cycle();
        logic acc;
        assert (!force_en || int'(force_sel) < N) else $error("illegal force_sel %0d", force_sel);
        push_expect();
        @(posedge Clk);
        for (int m = 0; m < 2; m++) begin
            acc = !m_valid[m] || wReady;
            if (Reset) begin
                m_valid[m] = 1'b0; m_data[m] = '0; m_id[m] = 0; m_ptr[m] = 0;
            end else if (acc) begin
                if (pend_w[m] >= 0) begin
                    m_data[m]  = data[pend_w[m]*W +: W];
                    m_id[m]    = pend_w[m];
                    m_valid[m] = 1'b1;
                    if (!force_en && m == 0) m_ptr[m] = (pend_w[m] + 1) % N;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        #1;
    endtask

    // Assert reset between edges and hold it across one edge.
    task automatic pulse_reset();
        #2;
        Reset = 1'b1;
        model_clear();
        push_expect();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_data_all(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) data[i*W +: W] = base + W'(i);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int m = 0; m < 2; m++) begin
                    chk("gnt",    m, 32'(gnt_o[m]),   32'(e.gnt[m]));
                    chk("wValid", m, 32'(valid_o[m]), 32'(e.valid[m]));
                    chk("wData",  m, 32'(wdata_o[m]), 32'(e.dat[m]));
                    chk("src_id", m, 32'(id_o[m]),    32'(e.id[m]));
                end
                if (valid_o[0] && wReady)
                    $display("xfer rr: src_id=%0d wData=%04h", id_o[0], wdata_o[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_clear();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;

        // Reset mid-stream
        req = 4'b1111; wReady = 1'b1; set_data_all(16'h0050);
        repeat (3) cycle();
        pulse_reset();
        cycle();

        // Round-robin fairness
        pulse_reset();
        set_data_all(16'h00A0);
        repeat (8) cycle();

        // Fixed priority patterns
        req = 4'b1010; cycle();
        req = 4'b1000; cycle();

        // Backpressure
        req = '0; force_en = 1'b1; force_sel = 2'd2; data[2*W +: W] = 16'h1234;
        cycle();
        force_en = 1'b0; wReady = 1'b0; req = 4'b0001; data[0 +: W] = 16'h0BEE;
        repeat (3) cycle();
        wReady = 1'b1; cycle();
        req = '0; cycle();

        // Legacy mux mode, then pointer continuity
        force_en = 1'b1; force_sel = 2'd0; data[0 +: W] = 16'd7; data[W +: W] = 16'd15;
        cycle();
        force_sel = 2'd1; cycle();
        force_en = 1'b0; req = 4'b1111; cycle();

        // Idle drain
        req = '0; cycle(); cycle();

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            req       = N'($urandom);
            for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
            wReady    = ($urandom_range(0, 9) < 7);
            force_en  = ($urandom_range(0, 9) == 0);
            force_sel = SW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else cycle();
        end

        force_en = 1'b0; req = '0;
        @(negedge Clk);
        #1;
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
